gmac_tx_channel_arbiter: RTL

//  N-channel transmit front-end for the custom GMAC single-channel TX port (Val/SoF/EoF/Req/Data).

---
 rtl/gmac_tx_channel_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/gmac_tx_channel_arbiter.sv
// rtl/gmac_tx_channel_arbiter.sv - round-robin N-channel TX front-end for the GMAC port
// Optional GMAC_ARB_STATS_EN adds per-channel completed-frame counters and a total abort counter.
module gmac_tx_channel_arbiter #(
    parameter int N_CH      = 2,
    parameter int DW        = 8,
    parameter int MAX_FRAME = 1500,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_CH-1:0]    ReqIn,
    output logic [N_CH-1:0]    ReqConfirm,
    input  logic [N_CH-1:0]    ValIn,
    input  logic [N_CH-1:0]    SoFIn,
    input  logic [N_CH-1:0]    EoFIn,
    input  logic [N_CH*DW-1:0] DataIn,
    output logic               ReqOut,
    input  logic               MacReqConfirm,
    output logic               ValOut,
    output logic               SoFOut,
    output logic               EoFOut,
    output logic [DW-1:0]      DataOut,
    output logic [CW-1:0]      ActiveCh,
    output logic               Busy,
`ifdef GMAC_ARB_STATS_EN
    output logic [N_CH*32-1:0] FrameCnt,
    output logic [15:0]        AbortCnt,
`endif
    output logic               AbortOut
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d, ch_q, ch_d, ch_next, cand;
    logic              started_q, started_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              req_out_q, req_out_d;
    logic [N_CH-1:0]   req_confirm_q, req_confirm_d;
    logic              val_out_q, val_out_d, sof_out_q, sof_out_d, eof_out_q, eof_out_d;
    logic [DW-1:0]     data_out_q, data_out_d;
    logic              abort_q, abort_d;
    logic              found, forward, do_abort;
    logic              ch_req, ch_val, ch_sof, ch_eof;
    logic [DW-1:0]     ch_data;
`ifdef GMAC_ARB_STATS_EN
    logic [N_CH*32-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]        abort_cnt_q, abort_cnt_d;
`endif

    assign ch_req  = ReqIn[ch_q];
    assign ch_val  = ValIn[ch_q];
    assign ch_sof  = SoFIn[ch_q];
    assign ch_eof  = EoFIn[ch_q];
    assign ch_data = DataIn[int'(ch_q)*DW +: DW];
    assign ch_next = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ch_d          = ch_q;
        started_d     = started_q;
        byte_cnt_d    = byte_cnt_q;
        to_cnt_d      = to_cnt_q;
        req_out_d     = req_out_q;
        req_confirm_d = '0;
        val_out_d     = 1'b0;
        sof_out_d     = 1'b0;
        eof_out_d     = 1'b0;
        data_out_d    = '0;
        abort_d       = 1'b0;
        found         = 1'b0;
        forward       = 1'b0;
        do_abort      = 1'b0;
        cand          = '0;
`ifdef GMAC_ARB_STATS_EN
        frame_cnt_d   = frame_cnt_q;
        abort_cnt_d   = abort_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Scan starting at the rotating pointer so every requester gets a turn.
                for (int i = 0; i < N_CH; i++) begin
                    cand = CW'((int'(ptr_q) + i) % N_CH);
                    if (!found && ReqIn[cand]) begin
                        found = 1'b1;
                        ch_d  = cand;
                    end
                end
                if (found) begin
                    req_out_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (MacReqConfirm) begin
                    req_out_d           = 1'b0;
                    req_confirm_d[ch_q] = 1'b1;
                    started_d           = 1'b0;
                    byte_cnt_d          = '0;
                    to_cnt_d            = '0;
                    state_d             = XFER;
                end else if (!ch_req) begin
                    req_out_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            XFER: begin
                if (ch_val) begin
                    to_cnt_d = '0;
                    if (!started_q) begin
                        if (ch_sof) begin
                            started_d  = 1'b1;
                            byte_cnt_d = 16'd1;
                            forward    = 1'b1;
                        end
                    end else if (ch_sof || byte_cnt_q >= 16'(MAX_FRAME)) begin
                        do_abort = 1'b1;
                    end else begin
                        forward = 1'b1;
                        if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end else if (started_q) begin
                    if (to_cnt_q == TW'(TIMEOUT - 1)) do_abort = 1'b1;
                    else to_cnt_d = to_cnt_q + TW'(1);
                end
                if (forward) begin
                    val_out_d  = 1'b1;
                    sof_out_d  = ch_sof;
                    eof_out_d  = ch_eof;
                    data_out_d = ch_data;
                    if (ch_eof) begin
                        state_d = IDLE;
                        ptr_d   = ch_next;
`ifdef GMAC_ARB_STATS_EN
                        frame_cnt_d[int'(ch_q)*32 +: 32] = frame_cnt_q[int'(ch_q)*32 +: 32] + 32'd1;
`endif
                    end
                end
                if (do_abort) begin
                    val_out_d = 1'b1;
                    eof_out_d = 1'b1;
                    abort_d   = 1'b1;
                    ptr_d     = ch_next;
                    to_cnt_d  = '0;
                    // An offending byte that itself carries EoF leaves nothing to drain.
                    state_d   = (ch_val && ch_eof) ? IDLE : DRAIN;
`ifdef GMAC_ARB_STATS_EN
                    if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
`endif
                end
            end
            DRAIN: begin
                if (ch_val) begin
                    to_cnt_d = '0;
                    if (ch_eof) state_d = IDLE;
                end else if (ch_req) begin
                    if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        to_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end else begin
                    to_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            ch_q          <= '0;
            started_q     <= 1'b0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            req_out_q     <= 1'b0;
            req_confirm_q <= '0;
            val_out_q     <= 1'b0;
            sof_out_q     <= 1'b0;
            eof_out_q     <= 1'b0;
            data_out_q    <= '0;
            abort_q       <= 1'b0;
`ifdef GMAC_ARB_STATS_EN
            frame_cnt_q   <= '0;
            abort_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ch_q          <= ch_d;
            started_q     <= started_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            req_out_q     <= req_out_d;
            req_confirm_q <= req_confirm_d;
            val_out_q     <= val_out_d;
            sof_out_q     <= sof_out_d;
            eof_out_q     <= eof_out_d;
            data_out_q    <= data_out_d;
            abort_q       <= abort_d;
`ifdef GMAC_ARB_STATS_EN
            frame_cnt_q   <= frame_cnt_d;
            abort_cnt_q   <= abort_cnt_d;
`endif
        end
    end

    assign ReqOut     = req_out_q;
    assign ReqConfirm = req_confirm_q;
    assign ValOut     = val_out_q;
    assign SoFOut     = sof_out_q;
    assign EoFOut     = eof_out_q;
    assign DataOut    = data_out_q;
    assign AbortOut   = abort_q;
    assign ActiveCh   = ch_q;
    assign Busy       = (state_q != IDLE);
`ifdef GMAC_ARB_STATS_EN
    assign FrameCnt   = frame_cnt_q;
    assign AbortCnt   = abort_cnt_q;
`endif

endmodule
